riscv_trap_ctrl: RTL and testbench

- Trap sequencer between the retiring pipeline stage and the CSR file.
- Arbitrates enabled interrupts against synchronous exceptions and xRET requests, and selects the target privilege level using medeleg/mideleg.
- Issues one-cycle CSR update strobes (epc/cause/tval plus mstatus stacking), tracks the current privilege level, and redirects fetch through a valid/ready handshake.

---
 rtl/riscv_state_pkg.sv | 41 ++++
 rtl/riscv_trap_prio.sv | 56 +++++
 rtl/riscv_trap_ctrl.sv | 165 ++++++++++++++++
 tb/tb_riscv_trap_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_state_pkg.sv
// ---- riscv_state_pkg: shared types and priority tables for the trap sequencer (rev 1.0) ----
`default_nettype none

package riscv_state_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    UPDATE   = 2'd1,
    REDIRECT = 2'd2
  } trap_state_t;

  typedef enum logic [1:0] {
    EV_TRAP_M = 2'd0,
    EV_TRAP_S = 2'd1,
    EV_RET_M  = 2'd2,
    EV_RET_S  = 2'd3
  } trap_event_t;

  localparam logic [1:0] PRV_U = 2'b00;
  localparam logic [1:0] PRV_S = 2'b01;
  localparam logic [1:0] PRV_H = 2'b10;
  localparam logic [1:0] PRV_M = 2'b11;

  localparam logic [1:0] TVEC_DIRECT   = 2'd0;
  localparam logic [1:0] TVEC_VECTORED = 2'd1;

  localparam int NUM_INT_PRIO = 9;
  localparam int NUM_EXC_PRIO = 14;

  // Element 0 is the highest priority cause.
  localparam logic [0:NUM_INT_PRIO-1][3:0] INT_PRIO = {
    4'd11, 4'd3, 4'd7, 4'd9, 4'd1, 4'd5, 4'd8, 4'd0, 4'd4
  };

  localparam logic [0:NUM_EXC_PRIO-1][3:0] EXC_PRIO = {
    4'd3, 4'd12, 4'd1, 4'd0, 4'd2, 4'd8, 4'd9, 4'd11, 4'd6, 4'd4, 4'd15, 4'd13, 4'd7, 4'd5
  };

endpackage

`default_nettype wire

// File: rtl/riscv_trap_prio.sv
// ---- riscv_trap_prio: priority encoder picking the winning trap cause and its target (rev 1.0) ----
`default_nettype none

module riscv_trap_prio
  import riscv_state_pkg::*;
#(
  parameter int                      N         = 16,
  parameter int                      NPRIO     = 14,
  parameter logic [0:NPRIO-1][3:0]   ORDER     = '0,
  parameter int                      IS_INT    = 0,
  parameter int                      HAS_SUPER = 1
) (
  input  logic [N-1:0] pending,
  input  logic [N-1:0] enable,
  input  logic [N-1:0] deleg,
  input  logic [1:0]   prv,
  input  logic         st_mie,
  input  logic         st_sie,
  output logic         taken,
  output logic [3:0]   cause,
  output logic         target_s
);

  logic [N-1:0] active;
  logic [N-1:0] deleg_eff;
  logic [N-1:0] eligible;

  always_comb begin
    active    = pending & enable;
    deleg_eff = (HAS_SUPER != 0) ? deleg : '0;
    eligible  = '0;
    for (int i = 0; i < N; i++) begin
      if (IS_INT == 0)
        eligible[i] = active[i];
      else if (deleg_eff[i])
        eligible[i] = active[i] && ((prv == PRV_U) || ((prv == PRV_S) && st_sie));
      else
        eligible[i] = active[i] && ((prv != PRV_M) || st_mie);
    end

    // Walk from lowest to highest priority so the last hit wins.
    taken    = 1'b0;
    cause    = 4'd0;
    target_s = 1'b0;
    for (int k = NPRIO - 1; k >= 0; k--) begin
      if (eligible[ORDER[k]]) begin
        taken    = 1'b1;
        cause    = ORDER[k];
        target_s = deleg_eff[ORDER[k]] && ((IS_INT != 0) || (prv != PRV_M));
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/riscv_trap_ctrl.sv
// ---- riscv_trap_ctrl: trap/xRET sequencer between retire stage, CSR file and fetch (rev 1.0) ----
`default_nettype none

module riscv_trap_ctrl
  import riscv_state_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int HAS_SUPER = 1,
  parameter int HAS_USER  = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [15:0]     ex_exceptions,
  input  logic            ex_mret,
  input  logic            ex_sret,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_tval,
  input  logic [11:0]     mip,
  input  logic [11:0]     mie,
  input  logic            st_mie,
  input  logic            st_sie,
  input  logic [1:0]      st_mpp,
  input  logic            st_spp,
  input  logic [15:0]     medeleg,
  input  logic [11:0]     mideleg,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] stvec,
  input  logic [XLEN-1:0] mepc,
  input  logic [XLEN-1:0] sepc,
  output logic [1:0]      prv,
  output logic            trap_m,
  output logic            trap_s,
  output logic            ret_m,
  output logic            ret_s,
  output logic [XLEN-1:0] trap_cause,
  output logic [XLEN-1:0] trap_epc,
  output logic [XLEN-1:0] trap_tval,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready
);

  trap_state_t state;
  trap_event_t ev_kind;

  logic       int_taken, int_s;
  logic [3:0] int_cause;
  logic       exc_taken, exc_s;
  logic [3:0] exc_cause;

  riscv_trap_prio #(
    .N(12), .NPRIO(NUM_INT_PRIO), .ORDER(INT_PRIO), .IS_INT(1), .HAS_SUPER(HAS_SUPER)
  ) u_int_prio (
    .pending(mip), .enable(mie), .deleg(mideleg), .prv(prv),
    .st_mie(st_mie), .st_sie(st_sie),
    .taken(int_taken), .cause(int_cause), .target_s(int_s)
  );

  riscv_trap_prio #(
    .N(16), .NPRIO(NUM_EXC_PRIO), .ORDER(EXC_PRIO), .IS_INT(0), .HAS_SUPER(HAS_SUPER)
  ) u_exc_prio (
    .pending(ex_exceptions), .enable(16'hFFFF), .deleg(medeleg), .prv(prv),
    .st_mie(st_mie), .st_sie(st_sie),
    .taken(exc_taken), .cause(exc_cause), .target_s(exc_s)
  );

  logic            sret_ok, is_trap, ev_fire, sel_s, tval_zero;
  logic [3:0]      sel_cause;
  logic [XLEN-1:0] tvec, base, trap_pc, new_pc, cause_full, tval_val;
  logic [1:0]      mret_prv;

  always_comb begin
    sret_ok    = ex_sret && (HAS_SUPER != 0);
    is_trap    = int_taken || exc_taken;
    ev_fire    = ex_valid && (is_trap || ex_mret || sret_ok);
    sel_cause  = int_taken ? int_cause : exc_cause;
    sel_s      = int_taken ? int_s : exc_s;
    tvec       = sel_s ? stvec : mtvec;
    base       = {tvec[XLEN-1:2], 2'b00};
    trap_pc    = (int_taken && (tvec[1:0] == TVEC_VECTORED))
               ? base + {{(XLEN-6){1'b0}}, sel_cause, 2'b00} : base;
    new_pc     = is_trap ? trap_pc : (ex_mret ? mepc : sepc);
    cause_full = {int_taken, {(XLEN-5){1'b0}}, sel_cause};
    tval_zero  = int_taken || (exc_cause == 4'd3) || (exc_cause == 4'd8) ||
                 (exc_cause == 4'd9) || (exc_cause == 4'd11);
    tval_val   = tval_zero ? '0 : ex_tval;
    // A reserved hypervisor encoding in mpp returns to U.
    if (HAS_USER == 0)
      mret_prv = PRV_M;
    else if (st_mpp == PRV_H)
      mret_prv = PRV_U;
    else
      mret_prv = st_mpp;
  end

  assign ex_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      ev_kind        <= EV_TRAP_M;
      prv            <= PRV_M;
      trap_m         <= 1'b0;
      trap_s         <= 1'b0;
      ret_m          <= 1'b0;
      ret_s          <= 1'b0;
      trap_cause     <= '0;
      trap_epc       <= '0;
      trap_tval      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      trap_m <= 1'b0;
      trap_s <= 1'b0;
      ret_m  <= 1'b0;
      ret_s  <= 1'b0;
      case (state)
        IDLE: begin
          if (ev_fire) begin
            state       <= UPDATE;
            redirect_pc <= new_pc;
            if (is_trap) begin
              trap_cause <= cause_full;
              trap_epc   <= ex_pc;
              trap_tval  <= tval_val;
              trap_m     <= !sel_s;
              trap_s     <= sel_s;
              ev_kind    <= sel_s ? EV_TRAP_S : EV_TRAP_M;
            end else if (ex_mret) begin
              ret_m   <= 1'b1;
              ev_kind <= EV_RET_M;
            end else begin
              ret_s   <= 1'b1;
              ev_kind <= EV_RET_S;
            end
          end
        end
        UPDATE: begin
          // prv moves only after the strobe cycle so the CSR file stacks the old level.
          state          <= REDIRECT;
          redirect_valid <= 1'b1;
          case (ev_kind)
            EV_TRAP_M: prv <= PRV_M;
            EV_TRAP_S: prv <= PRV_S;
            EV_RET_M:  prv <= mret_prv;
            EV_RET_S:  prv <= {1'b0, st_spp};
            default:   prv <= PRV_M;
          endcase
        end
        REDIRECT: begin
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_riscv_trap_ctrl.sv
// ---- tb_riscv_trap_ctrl: directed vector bench for the trap sequencer (rev 1.0) ----
`default_nettype none

module tb_riscv_trap_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ex_valid, ex_ready;
  logic [15:0] ex_exceptions;
  logic        ex_mret, ex_sret;
  logic [31:0] ex_pc, ex_tval;
  logic [11:0] mip, mie, mideleg;
  logic        st_mie, st_sie, st_spp;
  logic [1:0]  st_mpp, prv;
  logic [15:0] medeleg;
  logic [31:0] mtvec, stvec, mepc, sepc;
  logic        trap_m, trap_s, ret_m, ret_s;
  logic [31:0] trap_cause, trap_epc, trap_tval;
  logic        redirect_valid, redirect_ready;
  logic [31:0] redirect_pc;

  riscv_trap_ctrl #(.XLEN(32), .HAS_SUPER(1), .HAS_USER(1)) dut (
    .clk(clk), .rstn(rstn), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_exceptions(ex_exceptions), .ex_mret(ex_mret), .ex_sret(ex_sret),
    .ex_pc(ex_pc), .ex_tval(ex_tval), .mip(mip), .mie(mie),
    .st_mie(st_mie), .st_sie(st_sie), .st_mpp(st_mpp), .st_spp(st_spp),
    .medeleg(medeleg), .mideleg(mideleg), .mtvec(mtvec), .stvec(stvec),
    .mepc(mepc), .sepc(sepc), .prv(prv),
    .trap_m(trap_m), .trap_s(trap_s), .ret_m(ret_m), .ret_s(ret_s),
    .trap_cause(trap_cause), .trap_epc(trap_epc), .trap_tval(trap_tval),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] exc;
    logic        mret, sret;
    logic [11:0] mip, mie, mideleg;
    logic [15:0] medeleg;
    logic        smie, ssie, spp;
    logic [1:0]  mpp;
    logic [31:0] mtvec, stvec, mepc, sepc, pc, tval;
    logic        ev, chk_trap;
    logic [3:0]  strobes;
    logic [31:0] cause, epc, etval, rpc;
    logic [1:0]  eprv;
  } vec_t;

  vec_t vecs[$];
  vec_t v;
  int   tests = 0;
  int   failed = 0;

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic clr();
    v = '{default: '0};
    v.mtvec = 32'h200;
    v.stvec = 32'h400;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ex_exceptions = 0; ex_mret = 0; ex_sret = 0; ex_pc = 0; ex_tval = 0;
    mip = 0; mie = 0; mideleg = 0; medeleg = 0; st_mie = 0; st_sie = 0; st_spp = 0;
    st_mpp = 0; mtvec = 0; stvec = 0; mepc = 0; sepc = 0; redirect_ready = 0;
  endtask

  task automatic apply(input vec_t t, input int idx);
    ex_exceptions = t.exc; ex_mret = t.mret; ex_sret = t.sret; mip = t.mip; mie = t.mie;
    mideleg = t.mideleg; medeleg = t.medeleg; st_mie = t.smie; st_sie = t.ssie;
    st_spp = t.spp; st_mpp = t.mpp; mtvec = t.mtvec; stvec = t.stvec; mepc = t.mepc;
    sepc = t.sepc; ex_pc = t.pc; ex_tval = t.tval; ex_valid = 1;
    check("ready_pre", idx, 32'(ex_ready), 32'd1);
    @(posedge clk); #1;
    ex_valid = 0;
    if (t.ev) begin
      check("strobes", idx, 32'({trap_m, trap_s, ret_m, ret_s}), 32'(t.strobes));
      check("ready_busy", idx, 32'(ex_ready), 32'd0);
      if (t.chk_trap) begin
        check("cause", idx, trap_cause, t.cause);
        check("epc", idx, trap_epc, t.epc);
        check("tval", idx, trap_tval, t.etval);
      end
      @(posedge clk); #1;
      check("rvalid", idx, 32'(redirect_valid), 32'd1);
      check("rpc", idx, redirect_pc, t.rpc);
      check("prv", idx, 32'(prv), 32'(t.eprv));
      check("strobe_off", idx, 32'({trap_m, trap_s, ret_m, ret_s}), 32'd0);
      redirect_ready = 1;
      @(posedge clk); #1;
      redirect_ready = 0;
      check("rvalid_done", idx, 32'(redirect_valid), 32'd0);
      check("ready_back", idx, 32'(ex_ready), 32'd1);
    end else begin
      check("no_strobe", idx, 32'({trap_m, trap_s, ret_m, ret_s}), 32'd0);
      check("ready_stay", idx, 32'(ex_ready), 32'd1);
      check("prv_stay", idx, 32'(prv), 32'(t.eprv));
      check("no_redirect", idx, 32'(redirect_valid), 32'd0);
    end
  endtask

  initial begin
    idle_inputs();
    rstn = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_prv", 0, 32'(prv), 32'd3);
    check("rst_ready", 0, 32'(ex_ready), 32'd1);
    check("rst_strobes", 0, 32'({trap_m, trap_s, ret_m, ret_s, redirect_valid}), 32'd0);
    check("rst_rpc", 0, redirect_pc, 32'd0);
    check("rst_cause", 0, trap_cause, 32'd0);
    rstn = 1;
    @(posedge clk); #1;

    // Strobe order {trap_m, trap_s, ret_m, ret_s}; prv evolves down the table.
    clr(); v.exc = 16'h0004; v.pc = 32'h100; v.tval = 32'h13; v.ev = 1; v.chk_trap = 1;
    v.strobes = 4'b1000; v.cause = 32'd2; v.epc = 32'h100; v.etval = 32'h13; v.rpc = 32'h200; v.eprv = 2'd3; vecs.push_back(v);
    clr(); v.mret = 1; v.mpp = 2'd0; v.mepc = 32'h1234; v.ev = 1; v.strobes = 4'b0010; v.rpc = 32'h1234; v.eprv = 2'd0; vecs.push_back(v);
    clr(); v.exc = 16'h0100; v.medeleg = 16'h0100; v.pc = 32'h500; v.tval = 32'hDEAD; v.ev = 1; v.chk_trap = 1;
    v.strobes = 4'b0100; v.cause = 32'd8; v.epc = 32'h500; v.etval = 32'h0; v.rpc = 32'h400; v.eprv = 2'd1; vecs.push_back(v);
    clr(); v.sret = 1; v.spp = 0; v.sepc = 32'h2000; v.ev = 1; v.strobes = 4'b0001; v.rpc = 32'h2000; v.eprv = 2'd0; vecs.push_back(v);
    clr(); v.exc = 16'h0100; v.pc = 32'h600; v.tval = 32'h77; v.ev = 1; v.chk_trap = 1;
    v.strobes = 4'b1000; v.cause = 32'd8; v.epc = 32'h600; v.etval = 32'h0; v.rpc = 32'h200; v.eprv = 2'd3; vecs.push_back(v);
    clr(); v.mip = 12'h080; v.mie = 12'h080; v.smie = 1; v.mtvec = 32'h801; v.exc = 16'h0004; v.pc = 32'h300; v.tval = 32'h55;
    v.ev = 1; v.chk_trap = 1; v.strobes = 4'b1000; v.cause = 32'h8000_0007; v.epc = 32'h300; v.etval = 32'h0; v.rpc = 32'h81C; v.eprv = 2'd3; vecs.push_back(v);
    clr(); v.mip = 12'h880; v.mie = 12'h880; v.smie = 1; v.pc = 32'h304; v.ev = 1; v.chk_trap = 1;
    v.strobes = 4'b1000; v.cause = 32'h8000_000B; v.epc = 32'h304; v.etval = 32'h0; v.rpc = 32'h200; v.eprv = 2'd3; vecs.push_back(v);
    clr(); v.mip = 12'h200; v.mie = 12'h200; v.mideleg = 12'h200; v.smie = 1; v.ssie = 1; v.ev = 0; v.eprv = 2'd3; vecs.push_back(v);
    clr(); v.mip = 12'h080; v.mie = 12'h080; v.smie = 0; v.exc = 16'h000C; v.pc = 32'h308; v.tval = 32'h99; v.ev = 1; v.chk_trap = 1;
    v.strobes = 4'b1000; v.cause = 32'd3; v.epc = 32'h308; v.etval = 32'h0; v.rpc = 32'h200; v.eprv = 2'd3; vecs.push_back(v);
    clr(); v.exc = 16'h1003; v.pc = 32'h30C; v.tval = 32'hABC0; v.ev = 1; v.chk_trap = 1;
    v.strobes = 4'b1000; v.cause = 32'd12; v.epc = 32'h30C; v.etval = 32'hABC0; v.rpc = 32'h200; v.eprv = 2'd3; vecs.push_back(v);
    clr(); v.mret = 1; v.mpp = 2'd1; v.mepc = 32'h4000; v.ev = 1; v.strobes = 4'b0010; v.rpc = 32'h4000; v.eprv = 2'd1; vecs.push_back(v);
    clr(); v.exc = 16'h2000; v.medeleg = 16'h2000; v.pc = 32'h4010; v.tval = 32'hF00D; v.ev = 1; v.chk_trap = 1;
    v.strobes = 4'b0100; v.cause = 32'd13; v.epc = 32'h4010; v.etval = 32'hF00D; v.rpc = 32'h400; v.eprv = 2'd1; vecs.push_back(v);
    clr(); v.mip = 12'h002; v.mie = 12'h002; v.mideleg = 12'h002; v.ssie = 1; v.stvec = 32'h401; v.pc = 32'h4020;
    v.ev = 1; v.chk_trap = 1; v.strobes = 4'b0100; v.cause = 32'h8000_0001; v.epc = 32'h4020; v.etval = 32'h0; v.rpc = 32'h404; v.eprv = 2'd1; vecs.push_back(v);
    clr(); v.mip = 12'h080; v.mie = 12'h080; v.smie = 0; v.pc = 32'h4030; v.ev = 1; v.chk_trap = 1;
    v.strobes = 4'b1000; v.cause = 32'h8000_0007; v.epc = 32'h4030; v.etval = 32'h0; v.rpc = 32'h200; v.eprv = 2'd3; vecs.push_back(v);
    clr(); v.mret = 1; v.mpp = 2'd2; v.mepc = 32'h5000; v.ev = 1; v.strobes = 4'b0010; v.rpc = 32'h5000; v.eprv = 2'd0; vecs.push_back(v);
    clr(); v.ev = 0; v.eprv = 2'd0; vecs.push_back(v);
    clr(); v.mret = 1; v.mpp = 2'd3; v.mepc = 32'h6000; v.ev = 1; v.strobes = 4'b0010; v.rpc = 32'h6000; v.eprv = 2'd3; vecs.push_back(v);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i + 1);

    // Stalled redirect: target and handshake must hold while fetch is not ready.
    idle_inputs();
    ex_mret = 1; st_mpp = 2'd0; mepc = 32'h1234; ex_valid = 1;
    @(posedge clk); #1;
    ex_valid = 0; ex_mret = 0;
    check("stall_retm", 100, 32'(ret_m), 32'd1);
    @(posedge clk); #1;
    mepc = 32'h9999;
    for (int c = 0; c < 5; c++) begin
      check("stall_valid", 100 + c, 32'(redirect_valid), 32'd1);
      check("stall_pc", 100 + c, redirect_pc, 32'h1234);
      check("stall_ready", 100 + c, 32'(ex_ready), 32'd0);
      @(posedge clk); #1;
    end
    check("stall_prv", 105, 32'(prv), 32'd0);
    redirect_ready = 1;
    @(posedge clk); #1;
    redirect_ready = 0;
    check("stall_release", 106, 32'(ex_ready), 32'd1);

    // Asynchronous reset while waiting in REDIRECT.
    idle_inputs();
    ex_exceptions = 16'h0004; mtvec = 32'h200; ex_pc = 32'h700; ex_valid = 1;
    @(posedge clk); #1;
    ex_valid = 0; ex_exceptions = 0;
    @(posedge clk); #1;
    check("mid_valid", 200, 32'(redirect_valid), 32'd1);
    #2 rstn = 0;
    #1;
    check("mid_rst_valid", 201, 32'(redirect_valid), 32'd0);
    check("mid_rst_prv", 202, 32'(prv), 32'd3);
    @(negedge clk);
    rstn = 1;
    @(posedge clk); #1;
    check("mid_rst_ready", 203, 32'(ex_ready), 32'd1);
    check("mid_rst_strobes", 204, 32'({trap_m, trap_s, ret_m, ret_s, redirect_valid}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
